// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared constants and types for the pipeline control unit.
// Holds the stall bus width and its Stop/NoStop levels, the default exception
// vector, the excp_type codes, the control FSM state encoding and the helpers
// that decide which exception types are taken and where a flush redirects.
package pipe_ctrl_pkg;

  localparam int unsigned STALL_W_DEF    = 6;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

  // Stall bus levels: Stop holds a stage register, NoStop lets it advance.
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Prefix patterns, bit 0 = PC ... bit 5 = MEM.
  localparam logic [5:0] STALL_MEM  = 6'b111111;
  localparam logic [5:0] STALL_EX   = 6'b011111;
  localparam logic [5:0] STALL_ID   = 6'b001111;
  localparam logic [5:0] STALL_IF   = 6'b000111;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  localparam logic [1:0] EXCP_EXC  = 2'b01;
  localparam logic [1:0] EXCP_ERET = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_FLUSH    = 2'd2
  } pipe_state_t;

  // Only exception and eret start a flush sequence; 00/11 are ignored.
  function automatic logic excp_type_valid(input logic [1:0] t);
    return (t == EXCP_EXC) || (t == EXCP_ERET);
  endfunction

  // Exceptions go to the fixed vector, eret returns to the current EPC.
  function automatic logic [31:0] redirect_pc(input logic [1:0]  t,
                                              input logic [31:0] epc,
                                              input logic [31:0] vector);
    return (t == EXCP_EXC) ? vector : epc;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_encoder.sv
// pipe_ctrl_stall_encoder: combinational priority encoder from per-stage stall
// requests to a prefix-encoded stall vector. The deepest requesting stage
// wins, and every stage in front of it holds as well.
// Ports:
//   stallreq_if/id/ex/mem : per-stage stall requests
//   stall                 : prefix vector, bit k=1 holds stage register k
module pipe_ctrl_stall_encoder
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STALL_W = STALL_W_DEF
) (
  input  logic               stallreq_if,
  input  logic               stallreq_id,
  input  logic               stallreq_ex,
  input  logic               stallreq_mem,
  output logic [STALL_W-1:0] stall
);

  // Priority select: mem > ex > id > if.
  always_comb begin
    stall = STALL_W'(STALL_NONE);
    if (stallreq_mem) begin
      stall = STALL_W'(STALL_MEM);
    end else if (stallreq_ex) begin
      stall = STALL_W'(STALL_EX);
    end else if (stallreq_id) begin
      stall = STALL_W'(STALL_ID);
    end else if (stallreq_if) begin
      stall = STALL_W'(STALL_IF);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline control. Produces the stall bus and flush used
// by every pipeline register, and sequences precise exception/eret entry:
// freeze the pipe, wait out any data-cache stall, then flush for one cycle
// with a redirect PC.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   stallreq_*        : per-stage stall requests (if, id, ex, mem)
//   excp_valid/type   : MEM stage exception (01) or eret (10) report
//   excp_pc           : PC of the faulting instruction
//   cp0_epc           : current EPC, used as the eret target
//   stall             : combinational stall bus (bit k=1 holds register k)
//   flush, new_pc     : registered one-cycle flush and its redirect target
//   epc_out           : latched faulting PC for the CP0 write
//   stall_cycles      : cycles with any stall (PIPE_CTRL_PERF_EN, else 0)
//   flush_count       : number of flush cycles (PIPE_CTRL_PERF_EN, else 0)
// Build option: define PIPE_CTRL_PERF_EN to implement the two counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STALL_W    = STALL_W_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_if,
  input  logic               stallreq_id,
  input  logic               stallreq_ex,
  input  logic               stallreq_mem,
  input  logic               excp_valid,
  input  logic [1:0]         excp_type,
  input  logic [31:0]        excp_pc,
  input  logic [31:0]        cp0_epc,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [31:0]        new_pc,
  output logic [31:0]        epc_out,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        flush_count
);

  pipe_state_t        state_q, state_d;
  logic [1:0]         type_q, type_d;
  logic [31:0]        epc_q, epc_d;
  logic               flush_q, flush_d;
  logic [31:0]        new_pc_q, new_pc_d;
  logic [STALL_W-1:0] enc_stall;
  logic               excp_take;

  pipe_ctrl_stall_encoder #(
    .STALL_W (STALL_W)
  ) u_stall_encoder (
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .stall        (enc_stall)
  );

  assign excp_take = excp_valid && excp_type_valid(excp_type);

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      type_q   <= 2'b00;
      epc_q    <= 32'd0;
      flush_q  <= 1'b0;
      new_pc_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      epc_q    <= epc_d;
      flush_q  <= flush_d;
      new_pc_q <= new_pc_d;
    end
  end

  // Next state, stall bus and the values loaded on FLUSH entry.
  // flush/new_pc are computed for the next cycle so they come out of flops
  // exactly while the FSM sits in FLUSH.
  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    epc_d    = epc_q;
    flush_d  = 1'b0;
    new_pc_d = 32'd0;
    stall    = enc_stall;
    case (state_q)
      ST_RUN: begin
        if (excp_take) begin
          stall  = {STALL_W{STOP}};
          type_d = excp_type;
          epc_d  = excp_pc;
          if (stallreq_mem) begin
            state_d = ST_WAIT_MEM;
          end else begin
            state_d  = ST_FLUSH;
            flush_d  = 1'b1;
            new_pc_d = redirect_pc(excp_type, cp0_epc, EXC_VECTOR);
          end
        end
      end
      ST_WAIT_MEM: begin
        // Frozen until the data access completes; new reports are ignored.
        stall = {STALL_W{STOP}};
        if (!stallreq_mem) begin
          state_d  = ST_FLUSH;
          flush_d  = 1'b1;
          new_pc_d = redirect_pc(type_q, cp0_epc, EXC_VECTOR);
        end
      end
      ST_FLUSH: begin
        stall   = {STALL_W{NO_STOP}};
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign flush   = flush_q;
  assign new_pc  = new_pc_q;
  assign epc_out = epc_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_q;

  // Free-running wrap-around performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 32'd0;
    end else begin
      if (stall != '0) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (state_q == ST_FLUSH) begin
        flush_count_q <= flush_count_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule
